// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM states, immediate helper.
package cpu_pkg;

  localparam int unsigned IR_W      = 8;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned IMM_EXT_W = 64;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_STA = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB = 4'h4;
  localparam logic [OP_W-1:0] OP_AND = 4'h5;
  localparam logic [OP_W-1:0] OP_OR  = 4'h6;
  localparam logic [OP_W-1:0] OP_XOR = 4'h7;
  localparam logic [OP_W-1:0] OP_LDI = 4'h8;
  localparam logic [OP_W-1:0] OP_LDM = 4'h9;
  localparam logic [OP_W-1:0] OP_STM = 4'hA;
  localparam logic [OP_W-1:0] OP_JMP = 4'hB;
  localparam logic [OP_W-1:0] OP_JZ  = 4'hC;
  localparam logic [OP_W-1:0] OP_JC  = 4'hD;
  localparam logic [OP_W-1:0] OP_SHL = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  // Sign-extend the 4-bit instruction field; callers truncate to their width.
  function automatic logic [IMM_EXT_W-1:0] sext_imm(input logic [3:0] fld);
    return {{(IMM_EXT_W-4){fld[3]}}, fld};
  endfunction

endpackage

// File: rtl/alu_p.sv
// Combinational ALU: arithmetic/logic/shift on accumulator (a) and operand (b).
module alu_p
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum_c;

  // Result select; ops without their own case pass b through (LDA, LDI).
  always_comb begin
    y     = b;
    carry = 1'b0;
    sum_c = '0;
    case (op)
      OP_ADD: begin
        sum_c = {1'b0, a} + {1'b0, b};
        y     = sum_c[DATA_W-1:0];
        carry = sum_c[DATA_W];
      end
      OP_SUB: begin
        sum_c = {1'b0, a} - {1'b0, b};
        y     = sum_c[DATA_W-1:0];
        carry = sum_c[DATA_W];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y     = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      default: y = b;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU with register file, Z/C flags and req/ack memory port.
module acc_cpu_core
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NREG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [2:0]        dbg_state,
  output logic [DATA_W-1:0] dbg_acc
);

  localparam int unsigned RSEL_W = $clog2(NREG);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [IR_W-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d, c_q, c_d;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic                rf_we;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d, halted_q, halted_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [RSEL_W-1:0]   rsel_n;

  logic [OP_W-1:0]     op;
  logic [RSEL_W-1:0]   rsel;
  logic [DATA_W-1:0]   rval, imm_d, alu_b, alu_y;
  logic [ADDR_W-1:0]   imm_a;
  logic                alu_c, alu_z, hs;

  assign op    = ir_q[7:4];
  assign rsel  = ir_q[RSEL_W-1:0];
  assign rval  = rf_q[rsel];
  assign imm_d = DATA_W'(sext_imm(ir_q[3:0]));
  assign imm_a = ADDR_W'(sext_imm(ir_q[3:0]));
  assign alu_b = (op == OP_LDI) ? imm_d : rval;
  assign hs    = mem_req_q && mem_ack;

  alu_p #(.DATA_W(DATA_W)) u_alu (
    .a     (acc_q),
    .b     (alu_b),
    .op    (op),
    .y     (alu_y),
    .carry (alu_c),
    .zero  (alu_z)
  );

  // Next-state, datapath update and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    rf_we   = 1'b0;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (hs) begin
        ir_d    = mem_rdata[IR_W-1:0];
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_LDA, OP_AND, OP_OR, OP_XOR, OP_LDI: begin
            acc_d = alu_y;
            z_d   = alu_z;
          end
          OP_ADD, OP_SUB, OP_SHL: begin
            acc_d = alu_y;
            z_d   = alu_z;
            c_d   = alu_c;
          end
          OP_STA:         rf_we   = 1'b1;
          OP_LDM, OP_STM: state_d = ST_MEM;
          OP_JMP:         pc_d    = pc_q + imm_a;
          OP_JZ:          if (z_q) pc_d = pc_q + imm_a;
          OP_JC:          if (c_q) pc_d = pc_q + imm_a;
          OP_HLT:         state_d = ST_HALT;
          default:        ;
        endcase
      end
      ST_MEM: if (hs) begin
        state_d = ST_FETCH;
        if (op == OP_LDM) begin
          acc_d = mem_rdata;
          z_d   = (mem_rdata == '0);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase

    rsel_n     = ir_d[RSEL_W-1:0];
    mem_req_d  = (state_d == ST_FETCH) || (state_d == ST_MEM);
    mem_we_d   = (state_d == ST_MEM) && (ir_d[7:4] == OP_STM);
    mem_addr_d = (state_d == ST_MEM) ? ADDR_W'(rf_q[rsel_n]) : pc_d;
    halted_d   = (state_d == ST_HALT);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= '0;
      ir_q       <= '0;
      acc_q      <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      halted_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      z_q        <= z_d;
      c_q        <= c_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      halted_q   <= halted_d;
      if (rf_we) rf_q[rsel] <= acc_q;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = acc_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;
  assign dbg_acc   = acc_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: program table plus hand-written corner sequences.
module tb_acc_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance with wait-state memory model
  logic       rst = 1'b1;
  logic       mem_req, mem_we, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, dbg_acc;
  logic       mem_ack = 1'b0;
  logic [2:0] dbg_state;

  acc_cpu_core dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted),
    .dbg_state(dbg_state), .dbg_acc(dbg_acc)
  );

  // 16-bit, 8-register instance with zero-wait memory
  logic        rst2 = 1'b1;
  logic        req2, we2, halted2;
  logic [7:0]  addr2;
  logic [15:0] wdata2, rdata2, acc2;
  logic        ack2;
  logic [2:0]  st2;
  logic [15:0] mem2 [256];

  acc_cpu_core #(.DATA_W(16), .ADDR_W(8), .NREG(8)) dut2 (
    .clk(clk), .rst(rst2), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ack(ack2), .halted(halted2),
    .dbg_state(st2), .dbg_acc(acc2)
  );
  assign rdata2 = mem2[addr2];
  assign ack2   = req2;

  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  int   checks = 0;
  int   failures = 0;
  int   waits = 0;
  bit   block = 1'b0;
  int   cnt = 0;
  bit   hs_last = 1'b0;
  int   wr_count = 0;
  int   wr_req_cycles = 0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
  bit   stab_err = 1'b0;
  logic [7:0] t_addr, t_wdata;
  logic t_we;
  logic [7:0] prev_fetch = 8'h80, after_ff = 8'h00, after_02 = 8'h00;
  bit   seen_ff = 1'b0, seen_02 = 1'b0;

  // Memory side: commit writes and log fetch order on each handshake.
  always @(posedge clk) begin
    hs_last = mem_req && mem_ack;
    if (!rst && mem_req && mem_ack) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_count++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end else if (dbg_state == 3'd1) begin
        if (prev_fetch == 8'hFF && !seen_ff) begin after_ff = mem_addr; seen_ff = 1'b1; end
        if (prev_fetch == 8'h02 && !seen_02) begin after_02 = mem_addr; seen_02 = 1'b1; end
        prev_fetch = mem_addr;
      end
    end
  end

  // Ack generator with 'waits' stall cycles; also watches request stability.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      cnt = 0;
      mem_ack = 1'b0;
    end else begin
      if (hs_last) cnt = 0;
      if (cnt == 0) begin
        t_addr = mem_addr; t_wdata = mem_wdata; t_we = mem_we;
      end else if (mem_addr != t_addr || mem_wdata != t_wdata || mem_we != t_we) begin
        stab_err = 1'b1;
      end
      if (mem_we) wr_req_cycles++;
      mem_ack = !(block && dbg_state == 3'd3) && (cnt >= waits);
      cnt++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  // Counts cycles from the first fetch request until halted rises.
  task automatic run_to_halt(input int budget, output int cyc, output bit ok);
    bit started = 1'b0;
    cyc = 0;
    ok  = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (started) cyc++;
      if (halted) begin ok = 1'b1; break; end
      if (mem_req) started = 1'b1;
    end
  endtask

  typedef struct {
    string      name;
    int         waits;
    logic [7:0] exp_acc;
    int         exp_cyc;
  } vec_t;

  vec_t       vt [5];
  logic [7:0] vprog [5][16];

  initial begin
    int  cyc;
    bit  ok;
    bit  found;
    logic [7:0] acc_snap;

    vt[0] = '{name:"basic",     waits:0, exp_acc:8'h08, exp_cyc:10};
    vprog[0] = '{8'h85,8'h21,8'h83,8'h31,8'hF0,8'h00,8'h00,8'h00,
                 8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    vt[1] = '{name:"zc_flags",  waits:0, exp_acc:8'h00, exp_cyc:14};
    vprog[1] = '{8'h8F,8'h20,8'h81,8'h30,8'hC2,8'h87,8'h86,8'hD1,
                 8'h85,8'hF0,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    vt[2] = '{name:"basic_w2",  waits:2, exp_acc:8'h08, exp_cyc:20};
    vprog[2] = vprog[0];
    vt[3] = '{name:"sub_logic", waits:0, exp_acc:8'hF9, exp_cyc:22};
    vprog[3] = '{8'h83,8'h21,8'h81,8'h41,8'hD1,8'h80,8'h22,8'h87,
                 8'h52,8'h61,8'h72,8'hF0,8'h00,8'h00,8'h00,8'h00};
    vt[4] = '{name:"not_taken", waits:1, exp_acc:8'h06, exp_cyc:24};
    vprog[4] = '{8'h81,8'hE0,8'h20,8'hC1,8'h30,8'hD1,8'h30,8'hF0,
                 8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};

    clear_mem();
    for (int a = 0; a < 256; a++) mem2[a] = 16'h0000;

    // Reset values and first fetch timing
    repeat (2) @(negedge clk);
    chk("rst_req",    mem_req,   1'b0);
    chk("rst_we",     mem_we,    1'b0);
    chk("rst_addr",   mem_addr,  8'h00);
    chk("rst_halted", halted,    1'b0);
    chk("rst_state",  dbg_state, 3'd0);
    chk("rst_acc",    dbg_acc,   8'h00);
    rst = 1'b0;
    #1;
    chk("boot_state", dbg_state, 3'd0);
    chk("boot_req",   mem_req,   1'b0);
    @(negedge clk);
    chk("fetch1_req",   mem_req,   1'b1);
    chk("fetch1_addr",  mem_addr,  8'h00);
    chk("fetch1_state", dbg_state, 3'd1);

    // Table-driven programs
    for (int v = 0; v < 5; v++) begin
      waits = vt[v].waits;
      block = 1'b0;
      clear_mem();
      for (int a = 0; a < 16; a++) mem[a] = vprog[v][a];
      do_reset();
      run_to_halt(300, cyc, ok);
      chk({vt[v].name, "_halt"},   ok,      1'b1);
      chk({vt[v].name, "_acc"},    dbg_acc, vt[v].exp_acc);
      chk({vt[v].name, "_cycles"}, cyc,     vt[v].exp_cyc);
      repeat (3) @(negedge clk);
      chk({vt[v].name, "_frozen"}, {mem_req, dbg_state, dbg_acc}, {1'b0, 3'd4, vt[v].exp_acc});
    end

    // PC wrap and backward branch target
    waits = 0;
    clear_mem();
    mem[8'h00] = 8'hC3; mem[8'h01] = 8'h00; mem[8'h02] = 8'hB8;
    mem[8'h04] = 8'hD1; mem[8'h05] = 8'hF0; mem[8'h06] = 8'h86; mem[8'h07] = 8'hF0;
    mem[8'hFB] = 8'h8F; mem[8'hFC] = 8'hE0; mem[8'hFD] = 8'h80;
    mem[8'hFE] = 8'h20; mem[8'hFF] = 8'h00;
    prev_fetch = 8'h80; seen_ff = 1'b0; seen_02 = 1'b0;
    do_reset();
    run_to_halt(300, cyc, ok);
    chk("wrap_halt",     ok,       1'b1);
    chk("wrap_acc",      dbg_acc,  8'h06);
    chk("wrap_after_ff", {seen_ff, after_ff}, {1'b1, 8'h00});
    chk("jmp_target",    {seen_02, after_02}, {1'b1, 8'hFB});

    // STM/LDM with three wait cycles per access
    waits = 3;
    clear_mem();
    mem[0] = 8'h84;
    for (int a = 1; a <= 4; a++) mem[a] = 8'hE0;
    mem[5] = 8'h22; mem[6] = 8'h83;
    for (int a = 7; a <= 10; a++) mem[a] = 8'hE0;
    mem[11] = 8'h23; mem[12] = 8'h93; mem[13] = 8'hA2;
    mem[14] = 8'h80; mem[15] = 8'h92; mem[16] = 8'hF0;
    mem[8'h30] = 8'h5A;
    wr_count = 0; wr_req_cycles = 0; stab_err = 1'b0;
    do_reset();
    run_to_halt(400, cyc, ok);
    chk("stm_halt",       ok,            1'b1);
    chk("stm_count",      wr_count,      1);
    chk("stm_addr",       wr_addr,       8'h40);
    chk("stm_data",       wr_data,       8'h5A);
    chk("stm_mem",        mem[8'h40],    8'h5A);
    chk("stm_req_cycles", wr_req_cycles, 4);
    chk("req_stable",     stab_err,      1'b0);
    chk("ldm_acc",        dbg_acc,       8'h5A);
    chk("ws_cycles",      cyc,           97);

    // Reset while a MEM access is pending and unacknowledged
    waits = 0;
    clear_mem();
    mem[0] = 8'h87; mem[1] = 8'hE0; mem[2] = 8'h21; mem[3] = 8'h91;
    block = 1'b1;
    do_reset();
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (dbg_state == 3'd3) found = 1'b1;
    end
    chk("mem_reached", found, 1'b1);
    repeat (2) @(negedge clk);
    chk("mem_pending", {mem_req, mem_addr}, {1'b1, 8'h0E});
    rst = 1'b1;
    #1;
    chk("abort_req",    {mem_req, mem_we}, 2'b00);
    chk("abort_addr",   mem_addr,          8'h00);
    chk("abort_state",  dbg_state,         3'd0);
    chk("abort_acc",    dbg_acc,           8'h00);
    chk("abort_halted", halted,            1'b0);
    block = 1'b0;
    mem[0] = 8'h11; mem[1] = 8'hF0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("refetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
    run_to_halt(100, cyc, ok);
    chk("rf_cleared", {ok, dbg_acc}, {1'b1, 8'h00});

    // 16-bit datapath, 8 registers: SUB borrow and flags via branches
    mem2[0] = 16'h0081; mem2[1] = 16'h0027; mem2[2] = 16'h0080; mem2[3] = 16'h0047;
    mem2[4] = 16'h00C3; mem2[5] = 16'h00D1; mem2[6] = 16'h0080; mem2[7] = 16'h00F0;
    mem2[8] = 16'h0080; mem2[9] = 16'h00F0;
    @(negedge clk);
    rst2 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (halted2) found = 1'b1;
    end
    chk("w16_halt",  found, 1'b1);
    chk("w16_acc",   acc2,  16'hFFFF);
    chk("w16_state", st2,   3'd4);

    // Halted core stays put
    acc_snap = dbg_acc;
    repeat (4) @(negedge clk);
    chk("halt_hold", {halted, mem_req, dbg_acc}, {1'b1, 1'b0, acc_snap});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised successor to the 8-bit accumulator processor: a multi-cycle accumulator CPU with a generic-width datapath, an NREG-entry register file, zero/carry flags, conditional relative branches and a request/acknowledge memory port that tolerates wait states. It sits between the top-level integration and a single-ported instruction/data RAM. It exposes debug taps for the state, accumulator and halt status.

## Interface
- DATA_W, 8: datapath, accumulator and register width; must be ≥ 8.
- ADDR_W, 8: memory address and PC width; must be ≤ DATA_W.
- NREG, 4: register-file entries; power of two, 2..16. RSEL_W = clog2(NREG).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; sampled on the ack cycle.
- mem_ack  in  1  completes the pending transaction.
- halted  out  1  core executed HLT.
- dbg_state  out  3  current FSM state encoding.
- dbg_acc  out  DATA_W  accumulator value.

## Operation
- Instruction: low 8 bits of the fetched word. op = ir[7:4], fld = ir[3:0], r = ir[RSEL_W-1:0], imm = sign-extend(fld).
- 0 NOP. 1 LDA r: Acc←R[r]. 2 STA r: R[r]←Acc. 3 ADD r: Acc←Acc+R[r], C=carry-out. 4 SUB r: Acc←Acc−R[r], C=borrow. 5 AND, 6 OR, 7 XOR r.
- 8 LDI: Acc←imm sign-extended to DATA_W. 9 LDM r: Acc←mem[R[r][ADDR_W-1:0]]. A STM r: mem[R[r][ADDR_W-1:0]]←Acc.
- B JMP, C JZ, D JC: if taken (JMP always; JZ if Z; JC if C), PC←PC+imm mod 2^ADDR_W. PC already points past the branch.
- E SHL: Acc←Acc<<1, C=old MSB. F HLT.
- Z updates on every Acc write: Z=(new Acc==0). C updates only on ADD, SUB and SHL. All arithmetic is mod 2^DATA_W.
- FSM states:
  - BOOT(0): →FETCH.
  - FETCH(1): req, addr=PC, read. On ack: IR←rdata[7:0], PC←PC+1, →EXEC.
  - EXEC(2): Register and ALU ops and branches complete here; →FETCH. LDM/STM →MEM. HLT →HALT.
  - MEM(3): req, addr=R[r], we=(op==A), wdata=Acc. On ack: →FETCH; for LDM, Acc←rdata.
  - HALT(4): terminal; halted=1. Leaves only on reset.
- mem_req, mem_we and mem_addr are decoded from state. mem_wdata = Acc.

## Timing
- Reset values: state=BOOT, PC=0, Acc=0, all R=0, Z=C=0, IR=0, mem_req=0, mem_we=0, mem_addr=0, halted=0. Reset acts immediately; outputs take these values asynchronously.
- First fetch request is asserted in the cycle after reset deasserts.
- Handshake: a transaction completes in any cycle with mem_req && mem_ack, including the first request cycle (zero wait). mem_req, mem_we, mem_addr and mem_wdata are held stable until ack. mem_ack is ignored while mem_req=0.
- Cycle cost with w wait cycles per access:
  - Register, ALU, branch, NOP: 2+w.
  - LDM/STM: 3+2w.
- Register-file writes and flag updates become visible at the next edge. A STA followed by LDA of the same register returns the new value.
- PC wraps from 2^ADDR_W−1 to 0. Branch targets wrap mod 2^ADDR_W.
- Reset during a pending request drops mem_req at once. Memory must tolerate abandoned transactions.
- In HALT, mem_req=0, and all state is frozen except the debug outputs.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (OP_NOP … OP_HLT);
  - FSM state enum with the fixed encodings listed under Operation;
  - helper function for sign-extending imm.
- Sub-module alu_p, parameterised by DATA_W:
  - inputs a, b, op;
  - outputs y, carry, zero;
  - purely combinational.
- Register file and FSM stay in acc_cpu_core.

## Test plan
- Zero-wait memory; program LDI 5, STA r1, LDI 3, ADD r1, HLT → Acc=8, Z=0, C=0, halted=1 after 10 cycles from reset release.
- DATA_W=8: LDI −1 (0xFF), STA r0, LDI 1, ADD r0 → Acc=0x00, Z=1, C=1. A following JZ +2 skips two instructions.
- Memory with 3 wait cycles; STM r2 with R2=0x40, Acc=0x5A → a single write to 0x40 with data 0x5A. mem_addr/mem_wdata are stable for all 4 request cycles. A subsequent LDM r2 returns 0x5A.
- PC wrap: PC=0xFF holding NOP → the next fetch address is 0x00. JMP −8 at 0x02 targets 0xFB.
- Assert rst mid-MEM with ack withheld → mem_req=0 immediately and all registers at reset values. The first fetch after release is to address 0.
- DATA_W=16, NREG=8: SUB r7 with Acc=0x0000, R7=0x0001 → Acc=0xFFFF, C=1, Z=0.
